fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter in the RV32I CPU.
- Accepts the current PC over a valid/ready handshake and issues one request at a time to instruction memory.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to decode with a valid/ready handshake.
- A flush from branch/jump redirect discards all queued and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- XLEN, 32, address/data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  fetch address from program counter.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  fetch_queue accepts pc_in this cycle.
- flush  in  1  redirect; discard queued and in-flight fetches.
- imem_req  out  1  memory request valid.
- imem_addr  out  XLEN  memory request address.
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  XLEN  response instruction word.
- if_valid  out  1  head entry valid to decode.
- if_ready  in  1  decode consumes head entry.
- if_pc  out  XLEN  PC of head entry.
- if_instr  out  XLEN  instruction of head entry.
- if_misalign  out  1  head entry PC misaligned (see Optional Feature).
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, count=0, read/write pointers=0, req_pc=0. While rst=1: pc_ready=0, imem_req=0, imem_addr=0, if_valid=0, if_pc=0, if_instr=0, if_misalign=0.
- FSM states:
  - IDLE: pc_ready = !flush && count<DEPTH. On pc_valid&&pc_ready, capture pc_in into req_pc and go to REQ.
  - REQ: imem_req=1, imem_addr=req_pc, held stable until imem_gnt. On imem_gnt go to WAIT.
  - WAIT: on imem_rvalid, push {req_pc, imem_rdata} and go to IDLE.
  - DROP: on imem_rvalid, discard the data and go to IDLE.
  - pc_ready=0 in REQ, WAIT and DROP. At most one request outstanding.
- Slot reservation: a PC is accepted only when count<DEPTH. The in-flight entry therefore always has a free slot; no overflow is possible.
- Latency with zero-wait memory (gnt in the same cycle as req, rvalid the next cycle):
  - PC accepted cycle N; imem_req cycle N+1; rvalid cycle N+2; if_valid cycle N+3.
  - Peak rate: one instruction per 3 cycles.
- Output side:
  - if_valid = (count!=0).
  - if_pc, if_instr and if_misalign read combinationally from the head entry; all three are 0 when empty.
  - Pop on if_valid&&if_ready.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
- Flush (priority over all other events in its cycle):
  - Next cycle: count=0, pointers=0, if_valid=0. A same-cycle pop or push is discarded.
  - REQ without imem_gnt -> IDLE; imem_req drops next cycle.
  - REQ with imem_gnt -> DROP.
  - WAIT without imem_rvalid -> DROP.
  - WAIT with imem_rvalid -> IDLE, data discarded.
  - DROP stays DROP until rvalid.
  - IDLE: no PC is accepted in the flush cycle.
- imem_rvalid in IDLE or REQ is ignored; memory is reset together with this block.
- Reset mid-operation returns to the reset state regardless of FSM state; the outstanding request is abandoned.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A PC accepted with pc_in[1:0]!=0 issues no memory request.
  - The FSM stays in IDLE and pushes {pc_in, 32'h00000013 (NOP)} with misalign=1 in the cycle after acceptance.
  - if_misalign reflects the head entry's bit.
- Not defined:
  - if_misalign is tied to 0.
  - Misaligned PCs are fetched like any other; imem_addr = pc_in unmodified.

Test Plan:
- Reset then single fetch, zero-wait memory: pc_in=0x00000000 accepted cycle N -> imem_req/imem_addr=0 at N+1; rvalid rdata=0x00500093 at N+2; if_valid=1, if_pc=0, if_instr=0x00500093 at N+3.
- Sequential PCs 0x0,0x4,0x8,0xC with if_ready=0 -> fifo_count=4, pc_ready=0, no 5th request. Then if_ready=1 -> entries drain in order with matching pc/instr.
- Memory stall, gnt delayed 3 cycles -> imem_addr held stable and imem_req=1 throughout; one push after rvalid.
- Flush in WAIT, then rvalid 2 cycles later -> FSM DROP, response discarded, count=0. Next PC 0x100 fetched and delivered correctly.
- Flush with FIFO holding 2 entries and simultaneous if_ready=1 -> count=0 next cycle, if_valid=0, no stale entry later.
- With FETCH_MISALIGN_CHECK_EN, pc_in=0x00000006 -> no imem_req; entry if_pc=0x6, if_instr=0x00000013, if_misalign=1. Without the macro -> imem_addr=0x6, if_misalign=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: takes PCs from the program counter, issues one imem request at a time
// and buffers {pc, instr} pairs for decode. `define FETCH_MISALIGN_CHECK_EN turns misaligned PCs into NOPs.
module fetch_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [XLEN-1:0]          pc_in,
   input  logic                     pc_valid,
   output logic                     pc_ready,
   input  logic                     flush,
   output logic                     imem_req,
   output logic [XLEN-1:0]          imem_addr,
   input  logic                     imem_gnt,
   input  logic                     imem_rvalid,
   input  logic [XLEN-1:0]          imem_rdata,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [XLEN-1:0]          if_pc,
   output logic [XLEN-1:0]          if_instr,
   output logic                     if_misalign,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StReq  = 2'd1;
   localparam logic [1:0] StWait = 2'd2;
   localparam logic [1:0] StDrop = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q;
   logic [CntW-1:0] occupied;

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic            accept;
   logic            push;
   logic            pop;
   logic            misaligned;
   logic            mis_pend;
   logic [XLEN-1:0] push_pc;
   logic [XLEN-1:0] push_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

   logic            pend_q, pend_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            push_mis;
   logic            mis_mem [DEPTH];

   assign misaligned = (pc_in[1:0] != 2'b00);
   assign mis_pend   = pend_q;
`else
   assign misaligned = 1'b0;
   assign mis_pend   = 1'b0;
`endif

   // A pending misaligned push already owns a slot, so count it before accepting another PC.
   assign occupied = count_q + CntW'(mis_pend);
   assign pc_ready = !rst && (state_q == StIdle) && !flush && (occupied < CntW'(DEPTH));
   assign accept   = pc_valid && pc_ready;

   assign imem_req  = !rst && (state_q == StReq);
   assign imem_addr = imem_req ? req_pc_q : '0;

   assign if_valid   = !rst && (count_q != '0);
   assign if_pc      = if_valid ? pc_mem[rd_ptr_q] : '0;
   assign if_instr   = if_valid ? instr_mem[rd_ptr_q] : '0;
   assign fifo_count = count_q;
   assign pop        = if_valid && if_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign if_misalign = if_valid ? mis_mem[rd_ptr_q] : 1'b0;
`else
   assign if_misalign = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      req_pc_d   = req_pc_q;
      push       = 1'b0;
      push_pc    = req_pc_q;
      push_instr = imem_rdata;
`ifdef FETCH_MISALIGN_CHECK_EN
      pend_d     = 1'b0;
      pend_pc_d  = pend_pc_q;
      push_mis   = 1'b0;
`endif

      unique case (state_q)
         StIdle: begin
            if (accept && !misaligned) begin
               req_pc_d = pc_in;
               state_d  = StReq;
            end
         end
         StReq: begin
            if (flush) begin
               state_d = imem_gnt ? StDrop : StIdle;
            end else if (imem_gnt) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (flush) begin
               state_d = imem_rvalid ? StIdle : StDrop;
            end else if (imem_rvalid) begin
               push    = 1'b1;
               state_d = StIdle;
            end
         end
         StDrop: begin
            if (imem_rvalid) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned PCs skip memory and land as a NOP one cycle after acceptance.
      if (accept && misaligned) begin
         pend_d    = 1'b1;
         pend_pc_d = pc_in;
      end
      if (pend_q && !flush) begin
         push       = 1'b1;
         push_pc    = pend_pc_q;
         push_instr = Nop;
         push_mis   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         req_pc_q <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         req_pc_q <= req_pc_d;
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
               2'b10:   count_q <= count_q + CntW'(1);
               2'b01:   count_q <= count_q - CntW'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end
`endif

   // Storage needs no reset; entries are only visible through count_q.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         pc_mem[wr_ptr_q]    <= push_pc;
         instr_mem[wr_ptr_q] <= push_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
         mis_mem[wr_ptr_q]   <= push_mis;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle plus directed literal checks.
// Honours `define FETCH_MISALIGN_CHECK_EN the same way as the design.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam bit MisEn = 1'b1;
`else
   localparam bit MisEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_in = '0;
   logic        pc_valid = 1'b0;
   logic        pc_ready;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic        if_ready = 1'b0;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_misalign;
   logic [2:0]  fifo_count;

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
      .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_misalign(if_misalign),
      .fifo_count(fifo_count)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        mis;
   } ent_t;

   int checks = 0;
   int errors = 0;

   // Reference model: queued entries plus what the fetch side is doing (0 free, 1 requesting,
   // 2 awaiting data, 3 discarding data).
   ent_t        q[$];
   int          ph = 0;
   logic [31:0] rpc = '0;
   logic        mpend = 1'b0;
   logic [31:0] mpc = '0;

   // Memory responder knobs.
   int          gnt_delay = 0;
   int          rv_delay = 0;
   int          req_wait = 0;
   int          rv_cnt = 0;
   logic        rv_pend = 1'b0;
   logic [31:0] rv_addr = '0;

   function automatic logic [31:0] instr_of(logic [31:0] a);
      return 32'h0050_0093 + (a << 18);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      ent_t head;
      ent_t ne;
      logic exp_ready;
      logic exp_req;
      logic do_push;

      // Memory: drive this cycle's gnt/rvalid.
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hdead_beef;
      if (rst) begin
         rv_pend  = 1'b0;
         req_wait = 0;
      end else begin
         if (rv_pend) begin
            if (rv_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = instr_of(rv_addr);
               rv_pend     = 1'b0;
            end else begin
               rv_cnt--;
            end
         end
         if (imem_req) begin
            if (req_wait >= gnt_delay) begin
               imem_gnt = 1'b1;
               rv_pend  = 1'b1;
               rv_cnt   = rv_delay;
               rv_addr  = imem_addr;
               req_wait = 0;
            end else begin
               req_wait++;
            end
         end else begin
            req_wait = 0;
         end
      end

      // Compare DUT against the model's current state.
      exp_ready = !rst && (ph == 0) && !flush && ((q.size() + int'(mpend)) < DEPTH);
      exp_req   = !rst && (ph == 1);
      head      = (!rst && q.size() > 0) ? q[0] : '0;
      chk("pc_ready", 32'(pc_ready), 32'(exp_ready));
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      chk("imem_addr", imem_addr, exp_req ? rpc : 32'h0);
      chk("if_valid", 32'(if_valid), 32'(!rst && q.size() > 0));
      chk("if_pc", if_pc, head.pc);
      chk("if_instr", if_instr, head.instr);
      chk("if_misalign", 32'(if_misalign), 32'(head.mis));
      if (!rst) chk("fifo_count", 32'(fifo_count), 32'(q.size()));

      // Advance the model to the state after the coming rising edge.
      do_push = 1'b0;
      ne      = '0;
      if (rst) begin
         q.delete();
         ph    = 0;
         rpc   = '0;
         mpend = 1'b0;
      end else if (flush) begin
         q.delete();
         mpend = 1'b0;
         case (ph)
            1:       ph = imem_gnt ? 3 : 0;
            2:       ph = imem_rvalid ? 0 : 3;
            3:       if (imem_rvalid) ph = 0;
            default: ;
         endcase
      end else begin
         if (mpend) begin
            ne      = '{pc: mpc, instr: 32'h0000_0013, mis: 1'b1};
            do_push = 1'b1;
            mpend   = 1'b0;
         end
         case (ph)
            0: if (pc_valid && exp_ready) begin
               if (MisEn && pc_in[1:0] != 2'b00) begin
                  mpend = 1'b1;
                  mpc   = pc_in;
               end else begin
                  rpc = pc_in;
                  ph  = 1;
               end
            end
            1: if (imem_gnt) ph = 2;
            2: if (imem_rvalid) begin
               ne      = '{pc: rpc, instr: imem_rdata, mis: 1'b0};
               do_push = 1'b1;
               ph      = 0;
            end
            3: if (imem_rvalid) ph = 0;
            default: ;
         endcase
         if (q.size() > 0 && if_ready) void'(q.pop_front());
         if (do_push) q.push_back(ne);
      end
   end

   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents a PC and returns one cycle after it was accepted.
   task automatic fetch(logic [31:0] pc);
      int t = 0;
      pc_in    = pc;
      pc_valid = 1'b1;
      while (!pc_ready && t < 30) begin
         tick();
         t++;
      end
      chk("pc_accept", 32'(pc_ready), 32'd1);
      tick();
      pc_valid = 1'b0;
   endtask

   task automatic wait_count(int n);
      int t = 0;
      while (32'(fifo_count) != 32'(n) && t < 30) begin
         tick();
         t++;
      end
      chk("wait_count", 32'(fifo_count), 32'(n));
   endtask

   task automatic pop_one();
      if_ready = 1'b1;
      tick();
      if_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: PC offered but must not be taken.
      pc_valid = 1'b1;
      pc_in    = 32'h40;
      tick(2);
      chk("rst_pc_ready", 32'(pc_ready), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      rst      = 1'b0;
      pc_valid = 1'b0;
      tick();
      chk("post_rst_count", 32'(fifo_count), 32'd0);

      // Single zero-wait fetch: req at N+1, data at N+2, visible at N+3.
      fetch(32'h0);
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", imem_addr, 32'h0);
      tick();
      chk("t1_not_yet", 32'(if_valid), 32'd0);
      tick();
      chk("t1_valid", 32'(if_valid), 32'd1);
      chk("t1_pc", if_pc, 32'h0);
      chk("t1_instr", if_instr, 32'h0050_0093);
      pop_one();
      chk("t1_empty", 32'(fifo_count), 32'd0);

      // Fill to DEPTH with decode stalled, then drain in order.
      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h8);
      fetch(32'hC);
      wait_count(4);
      pc_valid = 1'b1;
      pc_in    = 32'h10;
      tick(3);
      chk("t2_full_ready", 32'(pc_ready), 32'd0);
      chk("t2_full_req", 32'(imem_req), 32'd0);
      chk("t2_full_count", 32'(fifo_count), 32'd4);
      pc_valid = 1'b0;
      if_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain_pc", if_pc, 32'(i * 4));
         chk("t2_drain_instr", if_instr, instr_of(32'(i * 4)));
         tick();
      end
      if_ready = 1'b0;
      chk("t2_drained", 32'(fifo_count), 32'd0);

      // Grant delayed three cycles: request held stable.
      gnt_delay = 3;
      fetch(32'h20);
      for (int i = 0; i < 3; i++) begin
         chk("t3_req_held", 32'(imem_req), 32'd1);
         chk("t3_addr_held", imem_addr, 32'h20);
         tick();
      end
      chk("t3_req_gnt", 32'(imem_req), 32'd1);
      gnt_delay = 0;
      wait_count(1);
      chk("t3_pc", if_pc, 32'h20);
      pop_one();

      // Flush while awaiting data; late response must be dropped.
      rv_delay = 2;
      fetch(32'h40);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_drop_req", 32'(imem_req), 32'd0);
      chk("t4_drop_ready", 32'(pc_ready), 32'd0);
      tick();
      chk("t4_rvalid_cycle_ready", 32'(pc_ready), 32'd0);
      tick();
      chk("t4_idle_ready", 32'(pc_ready), 32'd1);
      chk("t4_count", 32'(fifo_count), 32'd0);
      rv_delay = 0;
      fetch(32'h100);
      wait_count(1);
      chk("t4_pc", if_pc, 32'h100);
      chk("t4_instr", if_instr, 32'h0450_0093);
      pop_one();

      // Flush beats a simultaneous pop with two entries queued.
      fetch(32'h200);
      fetch(32'h204);
      wait_count(2);
      flush    = 1'b1;
      if_ready = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_count", 32'(fifo_count), 32'd0);
      chk("t5_valid", 32'(if_valid), 32'd0);
      tick(3);
      chk("t5_no_stale", 32'(if_valid), 32'd0);
      if_ready = 1'b0;

      // Misaligned PC.
      fetch(32'h6);
      if (MisEn) begin
         chk("t6_no_req", 32'(imem_req), 32'd0);
         tick();
         chk("t6_valid", 32'(if_valid), 32'd1);
         chk("t6_pc", if_pc, 32'h6);
         chk("t6_nop", if_instr, 32'h0000_0013);
         chk("t6_mis", 32'(if_misalign), 32'd1);
      end else begin
         chk("t6_req", 32'(imem_req), 32'd1);
         chk("t6_addr", imem_addr, 32'h6);
         wait_count(1);
         chk("t6_pc", if_pc, 32'h6);
         chk("t6_mis", 32'(if_misalign), 32'd0);
      end
      pop_one();

      // Reset in the middle of a stalled request.
      gnt_delay = 5;
      fetch(32'h300);
      tick();
      rst = 1'b1;
      tick();
      chk("t7_rst_req", 32'(imem_req), 32'd0);
      rst       = 1'b0;
      gnt_delay = 0;
      tick();
      chk("t7_count", 32'(fifo_count), 32'd0);
      chk("t7_req", 32'(imem_req), 32'd0);
      chk("t7_ready", 32'(pc_ready), 32'd1);
      fetch(32'h8);
      wait_count(1);
      chk("t7_instr", if_instr, instr_of(32'h8));
      pop_one();

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
